// File: rtl/hamming74_encoder_pkg.sv
// rtl/hamming74_encoder_pkg.sv - shared constants and FSM encoding for the Hamming(7,4) encoder
package hamming74_encoder_pkg;

  localparam int HAM_K = 4;
  localparam int HAM_N = 7;

  typedef enum logic {
    ST_READ  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/hamming74_parity.sv
// rtl/hamming74_parity.sv - combinational Hamming(7,4) parity generator
module hamming74_parity (
  input  logic [3:0] d,
  output logic [2:0] p
);

  assign p[0] = d[0] ^ d[1] ^ d[3];
  assign p[1] = d[0] ^ d[2] ^ d[3];
  assign p[2] = d[1] ^ d[2] ^ d[3];

endmodule

// File: rtl/hamming74_encoder.sv
// rtl/hamming74_encoder.sv - serial Hamming(7,4) encoder between an input bit FIFO and an output bit FIFO
module hamming74_encoder
  import hamming74_encoder_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FIFO_IN_DATA,
  output logic                 FIFO_IN_RE,
  input  logic                 FIFO_IN_EMPTY,
  output logic                 FIFO_OUT_DATA,
  output logic                 FIFO_OUT_WE,
  input  logic                 FIFO_OUT_FULL,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] CW_COUNT
);

  state_t               state, state_next;
  logic [2:0]           req_cnt, cap_cnt, wr_cnt;
  logic                 rd_pend;
  logic [HAM_K-1:0]     d_reg, d_next;
  logic [HAM_N-1:0]     cw_reg;
  logic [2:0]           parity;
  logic [CNT_WIDTH-1:0] cw_count;
  logic                 re, we;
  logic                 nibble_done, cw_done;

  assign nibble_done = rd_pend && (cap_cnt == 3'(HAM_K - 1));
  assign cw_done     = we && (wr_cnt == 3'(HAM_N - 1));

  // Nibble as it will look after this edge's capture, so the 4th bit reaches parity the same cycle
  always_comb begin
    d_next = d_reg;
    if (rd_pend) d_next[cap_cnt[1:0]] = FIFO_IN_DATA;
  end

  hamming74_parity u_parity (
    .d(d_next),
    .p(parity)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_READ;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_READ:  if (nibble_done) state_next = ST_WRITE;
      ST_WRITE: if (cw_done)     state_next = ST_READ;
      default:                   state_next = ST_READ;
    endcase
  end

  // Strobes are held off while reset is asserted so no FIFO entry is consumed or written then
  always_comb begin
    re = 1'b0;
    we = 1'b0;
    if (RESET) begin
      case (state)
        ST_READ:  re = !FIFO_IN_EMPTY && (req_cnt < 3'(HAM_K));
        ST_WRITE: we = !FIFO_OUT_FULL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      req_cnt  <= '0;
      cap_cnt  <= '0;
      wr_cnt   <= '0;
      rd_pend  <= 1'b0;
      d_reg    <= '0;
      cw_reg   <= '0;
      cw_count <= '0;
    end else begin
      rd_pend <= re;
      if (re) req_cnt <= req_cnt + 3'd1;
      if (rd_pend) begin
        d_reg   <= d_next;
        cap_cnt <= cap_cnt + 3'd1;
      end
      if (nibble_done) begin
        cw_reg  <= {parity, d_next};
        req_cnt <= '0;
        cap_cnt <= '0;
      end
      if (we) begin
        cw_reg <= {1'b0, cw_reg[HAM_N-1:1]};
        wr_cnt <= wr_cnt + 3'd1;
      end
      if (cw_done) begin
        wr_cnt   <= '0;
        cw_count <= cw_count + 1'b1;
      end
    end
  end

  assign FIFO_IN_RE    = re;
  assign FIFO_OUT_WE   = we;
  assign FIFO_OUT_DATA = cw_reg[0];
  assign BUSY          = (state == ST_WRITE) || (req_cnt != 3'd0) || rd_pend;
  assign CW_COUNT      = cw_count;

endmodule

// File: tb/tb_hamming74_encoder.sv
// tb/tb_hamming74_encoder.sv - self-checking bench for hamming74_encoder with bit-FIFO models
module tb_hamming74_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fifo_in_data = 1'b0;
  logic        fifo_in_re;
  logic        fifo_in_empty;
  logic        fifo_out_data;
  logic        fifo_out_we;
  logic        fifo_out_full;
  logic        busy;
  logic [15:0] cw_count;

  bit in_mem  [0:1023];
  bit out_mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, out_wr = 0, out_rd = 0;
  int cyc = 0, we_total = 0, re_viol = 0, we_viol = 0, overlap = 0;
  int re_log[$];
  logic [6:0] exp_q[$];
  bit empty_force = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign fifo_in_empty = (wr_ptr == rd_ptr) || empty_force;

  hamming74_encoder #(.CNT_WIDTH(16)) dut (
    .CLK          (clk),
    .RESET        (resetn),
    .FIFO_IN_DATA (fifo_in_data),
    .FIFO_IN_RE   (fifo_in_re),
    .FIFO_IN_EMPTY(fifo_in_empty),
    .FIFO_OUT_DATA(fifo_out_data),
    .FIFO_OUT_WE  (fifo_out_we),
    .FIFO_OUT_FULL(fifo_out_full),
    .BUSY         (busy),
    .CW_COUNT     (cw_count)
  );

  // Upstream FIFO with read latency 1 and downstream FIFO capture
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_in_re) begin
      re_log.push_back(cyc);
      if (fifo_in_empty) re_viol <= re_viol + 1;
      else begin
        fifo_in_data <= in_mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
    end
    if (fifo_out_we) begin
      if (fifo_out_full) we_viol <= we_viol + 1;
      out_mem[out_wr] <= fifo_out_data;
      out_wr          <= out_wr + 1;
      we_total        <= we_total + 1;
    end
    if (fifo_in_re && fifo_out_we) overlap <= overlap + 1;
  end

  // Transmission order: d0..d3 then p0,p1,p2, parity as even count of ones
  function automatic logic [6:0] ref_cw(input logic [3:0] d);
    int b [7];
    logic [6:0] r;
    for (int i = 0; i < 4; i++) b[i] = int'(d[i]);
    b[4] = (b[0] + b[1] + b[3]) % 2;
    b[5] = (b[0] + b[2] + b[3]) % 2;
    b[6] = (b[1] + b[2] + b[3]) % 2;
    for (int i = 0; i < 7; i++) r[i] = (b[i] != 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_nibble(input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      in_mem[wr_ptr] = d[i];
      wr_ptr = wr_ptr + 1;
    end
    exp_q.push_back(ref_cw(d));
  endtask

  task automatic check_out(input string tag);
    logic [6:0] o;
    while (exp_q.size() > 0) begin
      for (int i = 0; i < 7; i++) o[i] = out_mem[out_rd + i];
      check(tag, 32'(o), 32'(exp_q.pop_front()));
      out_rd = out_rd + 7;
    end
  endtask

  task automatic wait_cw(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && int'(cw_count) != target; i++) @(negedge clk);
    check(tag, 32'(cw_count), 32'(target));
  endtask

  task automatic wait_we(input int target, input int budget);
    for (int i = 0; i < budget && we_total != target; i++) @(negedge clk);
    check("we_wait", 32'(we_total), 32'(target));
  endtask

  initial begin
    int base;
    int c0;
    logic [6:0] cw;

    resetn        = 1'b0;
    fifo_out_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_re",    32'(fifo_in_re),    32'd0);
    check("rst_we",    32'(fifo_out_we),   32'd0);
    check("rst_data",  32'(fifo_out_data), 32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_count", 32'(cw_count),      32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // single nibble d0..d3 = 1,0,1,1
    base = we_total;
    push_nibble(4'b1101);
    wait_cw("t1_count", 1, 100);
    repeat (2) @(negedge clk);
    check("t1_we_pulses", 32'(we_total - base), 32'd7);
    check("t1_busy", 32'(busy), 32'd0);
    check_out("t1_cw");

    // back-to-back 0000 then 1111, 12-cycle period
    re_log.delete();
    push_nibble(4'b0000);
    push_nibble(4'b1111);
    wait_cw("t2_count", 3, 200);
    repeat (2) @(negedge clk);
    check("t2_re_count", 32'(re_log.size()), 32'd8);
    check("t2_period", 32'(re_log[4] - re_log[0]), 32'd12);
    check_out("t2_cw");

    // FULL stall after 3rd WE
    base = we_total;
    push_nibble(4'b1010);
    cw = exp_q[exp_q.size() - 1];
    wait_we(base + 3, 100);
    fifo_out_full = 1'b1;
    repeat (5) begin
      #1;
      check("t3_we_stall", 32'(fifo_out_we), 32'd0);
      check("t3_data_hold", 32'(fifo_out_data), 32'(cw[3]));
      @(negedge clk);
    end
    fifo_out_full = 1'b0;
    check("t3_frozen", 32'(we_total - base), 32'd3);
    wait_cw("t3_count", 4, 100);
    check_out("t3_cw");

    // EMPTY toggling during READ
    push_nibble(4'b0111);
    for (int i = 0; i < 14; i++) begin
      empty_force = ~empty_force;
      @(negedge clk);
    end
    empty_force = 1'b0;
    wait_cw("t4_count", 5, 100);
    check("t4_re_viol", 32'(re_viol), 32'd0);
    check_out("t4_cw");

    // reset after 4th WE of a codeword
    base = we_total;
    push_nibble(4'b1001);
    wait_we(base + 4, 100);
    resetn = 1'b0;
    @(negedge clk);
    check("t5_we", 32'(fifo_out_we), 32'd0);
    check("t5_data", 32'(fifo_out_data), 32'd0);
    check("t5_count", 32'(cw_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    void'(exp_q.pop_back());
    out_rd = out_wr;
    @(negedge clk);
    push_nibble(4'b0110);
    wait_cw("t5_recount", 1, 100);
    check_out("t5_cw");

    // 200 random bits with random back-pressure
    base = we_total;
    c0   = int'(cw_count);
    for (int i = 0; i < 50; i++) push_nibble(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4000 && int'(cw_count) != c0 + 50; i++) begin
      fifo_out_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    fifo_out_full = 1'b0;
    check("t6_count", 32'(cw_count), 32'(c0 + 50));
    repeat (2) @(negedge clk);
    check("t6_we_pulses", 32'(we_total - base), 32'd350);
    check_out("t6_cw");

    check("re_while_empty", 32'(re_viol), 32'd0);
    check("we_while_full", 32'(we_viol), 32'd0);
    check("re_we_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
